// File: rtl/vector_mem_sequencer.sv
// Memory-access stage: scalar byte (LB/SB) and multi-lane vector (LVI/SVI) transfers
// against a single-port byte-wide memory, one lane per cycle, with a pipeline stall.
`timescale 1ns/1ps

module vector_mem_sequencer #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      vector_mem,
    input  logic                      mem_write,
    input  logic                      mem_to_reg,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [LANES*DATA_W-1:0]   wdata,
    output logic                      busy,
    output logic                      done,
    output logic [LANES*DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic                      mem_re,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int K_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BUS_W = LANES * DATA_W;

    typedef enum logic [2:0] {IDLE, STORE, LOAD, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [K_W-1:0]      k_q, k_d;
    logic                vec_q, vec_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [BUS_W-1:0]    wbuf_q, wbuf_d;
    logic [BUS_W-1:0]    buf_q, buf_d;
    logic [BUS_W-1:0]    rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic [K_W-1:0]      last_k;
    logic [K_W-1:0]      k_next;

    assign last_k = vec_q ? K_W'(LANES - 1) : '0;
    assign k_next = k_q + K_W'(1);

    always_comb begin
        // NOTE: every variable gets its default before the case so no path infers a latch.
        state_d     = state_q;
        k_d         = k_q;
        vec_d       = vec_q;
        base_d      = base_q;
        wbuf_d      = wbuf_q;
        buf_d       = buf_q;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start && (mem_write || mem_to_reg)) begin
                    vec_d      = vector_mem;
                    base_d     = base_addr;
                    wbuf_d     = wdata;
                    buf_d      = '0;
                    k_d        = '0;
                    busy_d     = 1'b1;
                    mem_addr_d = base_addr;
                    if (mem_write) begin
                        state_d     = STORE;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = wdata[DATA_W-1:0];
                    end else begin
                        state_d  = LOAD;
                        mem_re_d = 1'b1;
                    end
                end
            end
            STORE: begin
                if (k_q == last_k) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    k_d         = k_next;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = base_q + ADDR_W'(k_next);
                    mem_wdata_d = wbuf_q[int'(k_next)*DATA_W +: DATA_W];
                end
            end
            LOAD: begin
                // Read data trails the request by one cycle, so this cycle returns lane k-1.
                if (k_q != '0) begin
                    buf_d[(int'(k_q) - 1)*DATA_W +: DATA_W] = mem_rdata;
                end
                if (k_q == last_k) begin
                    state_d = DRAIN;
                end else begin
                    k_d        = k_next;
                    mem_re_d   = 1'b1;
                    mem_addr_d = base_q + ADDR_W'(k_next);
                end
            end
            DRAIN: begin
                buf_d[int'(k_q)*DATA_W +: DATA_W] = mem_rdata;
                rdata_d = vec_q ? buf_d : BUS_W'(buf_d[DATA_W-1:0]);
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            vec_q       <= 1'b0;
            base_q      <= '0;
            wbuf_q      <= '0;
            buf_q       <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q     <= state_d;
            k_q         <= k_d;
            vec_q       <= vec_d;
            base_q      <= base_d;
            wbuf_q      <= wbuf_d;
            buf_q       <= buf_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Scoreboard bench for vector_mem_sequencer: expected memory accesses and completions
// are queued when a request is driven and compared as the DUT produces them.
`timescale 1ns/1ps

module tb_vector_mem_sequencer;

    localparam int LANES  = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    vector_mem;
    logic                    mem_write;
    logic                    mem_to_reg;
    logic [ADDR_W-1:0]       base_addr;
    logic [LANES*DATA_W-1:0] wdata;
    logic                    busy;
    logic                    done;
    logic [LANES*DATA_W-1:0] rdata;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_we;
    logic                    mem_re;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata = '0;

    vector_mem_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .vector_mem (vector_mem),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .base_addr  (base_addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } acc_t;

    typedef struct {
        int          cyc;
        bit          is_load;
        logic [31:0] rdata;
    } done_t;

    acc_t        acc_q[$];
    done_t       done_q[$];
    int          checks = 0;
    int          errors = 0;
    int          edge_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] rdata_exp = '0;
    logic [7:0]  tb_mem  [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Byte memory with one-cycle read latency.
    always @(posedge clk) begin
        if (!rst) begin
            if (mem_we) tb_mem[mem_addr] = mem_wdata;
            if (mem_re) mem_rdata <= tb_mem.exists(mem_addr) ? tb_mem[mem_addr] : 8'h00;
        end
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin : monitor
        acc_t  a;
        done_t d;
        if (!rst) begin
            if (mem_we || mem_re) begin
                check("we_re_exclusive", mem_we & mem_re, 0);
                check("access_expected", acc_q.size() != 0, 1);
                if (acc_q.size() != 0) begin
                    a = acc_q.pop_front();
                    check("acc_we", mem_we, a.we);
                    check("acc_addr", mem_addr, a.addr);
                    if (a.we) check("acc_wdata", mem_wdata, a.data);
                    check("acc_cycle", edge_cnt, a.cyc);
                end
            end
            if (done) begin
                done_cnt++;
                check("busy_during_done", busy, 1);
                check("done_expected", done_q.size() != 0, 1);
                if (done_q.size() != 0) begin
                    d = done_q.pop_front();
                    check("done_cycle", edge_cnt, d.cyc);
                    if (d.is_load) rdata_exp = d.rdata;
                end
            end
            check("rdata", rdata, rdata_exp);
        end
    end

    task automatic preload(input logic [31:0] addr, input logic [7:0] data);
        tb_mem[addr]  = data;
        ref_mem[addr] = data;
    endtask

    task automatic run_op(input logic vec, input logic w, input logic r,
                          input logic [31:0] base, input logic [31:0] wd, input bit extra);
        int          n;
        int          s;
        int          d0;
        acc_t        a;
        done_t       d;
        logic [31:0] exp_rd;
        logic [31:0] addr;
        n = vec ? LANES : 1;
        exp_rd = '0;
        @(negedge clk);
        #1;
        check("idle_busy", busy, 0);
        vector_mem = vec;
        mem_write  = w;
        mem_to_reg = r;
        base_addr  = base;
        wdata      = wd;
        start      = 1'b1;
        s  = edge_cnt;
        d0 = done_cnt;
        if (w || r) begin
            for (int k = 0; k < n; k++) begin
                addr   = base + k;
                a.we   = w;
                a.addr = addr;
                a.data = wd[k*8 +: 8];
                a.cyc  = s + 1 + k;
                acc_q.push_back(a);
                if (w) ref_mem[addr] = wd[k*8 +: 8];
                else   exp_rd[k*8 +: 8] = ref_mem.exists(addr) ? ref_mem[addr] : 8'h00;
            end
            d.cyc     = s + n + (w ? 1 : 2);
            d.is_load = !w;
            d.rdata   = exp_rd;
            done_q.push_back(d);
        end
        @(negedge clk);
        start = 1'b0;
        if (extra) begin
            @(negedge clk);
            start      = 1'b1;
            mem_write  = 1'b1;
            vector_mem = 1'b1;
            base_addr  = 32'h0000_0ABC;
            @(negedge clk);
            start = 1'b0;
        end
        if (w || r) begin
            for (int i = 0; i < 30; i++) begin
                if (done_cnt != d0) break;
                @(negedge clk);
                #1;
            end
            check("done_timeout", done_cnt != d0, 1);
        end else begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                #1;
                check("ignored_busy", busy, 0);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        vector_mem = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        base_addr  = '0;
        wdata      = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", mem_we, 0);
        check("rst_re", mem_re, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        rst = 1'b0;

        preload(32'h200, 8'h11); preload(32'h201, 8'h22);
        preload(32'h202, 8'h33); preload(32'h203, 8'h44);
        preload(32'h002, 8'h9F);
        preload(32'hFFFF_FFFE, 8'hA1); preload(32'hFFFF_FFFF, 8'hB2);
        preload(32'h0000_0000, 8'hC3); preload(32'h0000_0001, 8'hD4);

        run_op(1, 1, 0, 32'h100, 32'hDDCC_BBAA, 0);      // SVI
        run_op(1, 0, 1, 32'h200, 32'h0, 0);              // LVI
        run_op(0, 0, 1, 32'h002, 32'h0, 0);              // LB zero-extended
        run_op(0, 1, 0, 32'h300, 32'h1234_565A, 0);      // SB, rdata must hold
        run_op(1, 0, 1, 32'hFFFF_FFFE, 32'h0, 0);        // LVI wrapping
        run_op(1, 1, 0, 32'h400, 32'h8877_6655, 1);      // SVI with ignored start
        run_op(1, 0, 0, 32'h500, 32'hFFFF_FFFF, 0);      // neither strobe
        run_op(1, 1, 1, 32'h600, 32'h0403_0201, 0);      // store wins
        run_op(1, 0, 1, 32'h100, 32'h0, 0);              // read back SVI data
        run_op(1, 0, 1, 32'h600, 32'h0, 0);              // read back store-wins data

        // Async reset in the middle of an LVI.
        @(negedge clk);
        vector_mem = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1;
        base_addr  = 32'h200; start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            acc_t a;
            a.we = 1'b0; a.addr = 32'h200 + k; a.data = '0; a.cyc = edge_cnt + 1 + k;
            acc_q.push_back(a);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        rdata_exp = '0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_re", mem_re, 0);
        check("arst_we", mem_we, 0);
        check("arst_done", done, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_rdata", rdata, 0);
        check("arst_acc_seen", acc_q.size(), 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("arst_hold_re", mem_re, 0);
            check("arst_hold_done", done, 0);
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("post_rst_idle", busy | mem_re | mem_we | done, 0);
        end
        run_op(1, 0, 1, 32'h200, 32'h0, 0);

        repeat (3) @(negedge clk);
        check("acc_queue_drained", acc_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
- Memory-access stage directly downstream of the instruction decoder.
- Consumes the decoder's vectorMem, MemW and MemtoReg strobes together with the effective address from the ALU.
- Performs scalar byte accesses (LB/SB) and multi-lane vector accesses (LVI/SVI) against a single-port byte-wide data memory, one lane per cycle.
- Raises busy so the pipeline stalls until the transfer completes.

Parameters:
- LANES, 4, number of vector lanes moved by LVI/SVI.
- DATA_W, 8, lane width in bits; equals the memory data width.
- ADDR_W, 32, byte address width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle request from the decode/execute stage.
- vector_mem  input  1  decoder vectorMem: 1 = vector access (LANES elements), 0 = scalar (1 element).
- mem_write  input  1  decoder MemW: store request.
- mem_to_reg  input  1  decoder MemtoReg: load request.
- base_addr  input  ADDR_W  effective address from the ALU.
- wdata  input  LANES*DATA_W  store data; lane k is bits [k*DATA_W +: DATA_W].
- busy  output  1  transfer in progress; pipeline stall.
- done  output  1  one-cycle completion pulse.
- rdata  output  LANES*DATA_W  load result.
- mem_addr  output  ADDR_W  memory address.
- mem_we  output  1  memory write enable.
- mem_re  output  1  memory read enable.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid exactly one cycle after the mem_re cycle.

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, mem_we, mem_re, mem_addr, mem_wdata, rdata, element counter and assembly buffer all 0. Reset mid-transfer aborts immediately; no further mem_we or mem_re, and no done.
- All outputs are registered. N = LANES if vector_mem=1, else 1.
- States: IDLE, STORE, LOAD, DRAIN, DONE.
- Acceptance:
  - start is sampled only in IDLE. start while busy=1 is ignored.
  - start with mem_write=1 goes to STORE. When mem_write=1 and mem_to_reg=1 are both set, store wins.
  - start with mem_write=0 and mem_to_reg=1 goes to LOAD.
  - start with neither set is ignored; the block stays IDLE and no done is produced.
  - On acceptance the block latches base_addr, wdata and N, and clears the counter k.
- STORE, one cycle per element k=0..N-1:
  - mem_we=1, mem_addr=base+k, mem_wdata=lane k.
  - After element N-1, go to DONE.
- LOAD, one cycle per element k=0..N-1:
  - mem_re=1, mem_addr=base+k.
  - Each cycle captures mem_rdata into buffer lane k-1 (for k>0).
  - After element N-1, go to DRAIN.
- DRAIN:
  - mem_re=0; capture the last byte into buffer lane N-1.
  - Copy the buffer to rdata (lanes >= N zero-filled, so a scalar LB result is zero-extended). Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in all states except IDLE.
- Latency, counted from the start edge as cycle 0:
  - Store: done in cycle N+1.
  - Load: done in cycle N+2.
- rdata:
  - Changes only at the end of a load's DRAIN cycle.
  - Holds its value through stores and idle periods.
  - A store never modifies it.
- Address arithmetic: base+k modulo 2^ADDR_W; wraps from all-ones to 0 without error.
- mem_we and mem_re are never both 1. Both are 0 in IDLE, DRAIN and DONE.
- mem_addr and mem_wdata hold their last value when not accessing.
- A new start is accepted in the first IDLE cycle after done, i.e. back-to-back gap = 1 cycle.

Test Plan:
- Reset, then SVI: vector_mem=1, mem_write=1, base=0x100, wdata=0xDDCCBBAA -> mem_we cycles 1-4 at addresses 0x100..0x103 with data AA, BB, CC, DD; done in cycle 5; busy cycles 1-5.
- LVI: memory 0x200..0x203 = 11, 22, 33, 44 -> mem_re cycles 1-4; done in cycle 6; rdata=0x44332211.
- Scalar LB at 0x2 (memory=0x9F) -> one read; done in cycle 3; rdata=0x0000009F. Scalar SB -> single write, done in cycle 2.
- Wrap-around: LVI at base=0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
- Ignored starts:
  - start pulsed in cycle 2 of a store -> no extra accesses, exactly one done.
  - start with mem_write=0 and mem_to_reg=0 -> busy stays 0.
  - mem_write=mem_to_reg=1 -> performs a store.
- Async reset asserted mid-LVI (cycle 2) -> outputs 0 immediately, no done; rdata keeps 0; the next LVI completes normally.
